// File: rtl/mux_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mux_stream                                                                 |
// | N-channel valid/ready stream mux into one registered output stage.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module mux_stream #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = 0,
    localparam int SELW = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_src
);

    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  out_src_q,   out_src_d;
    logic [SELW-1:0]  ptr_q,       ptr_d;

    logic             grant_vld;
    logic [SELW-1:0]  grant_idx;
    logic             space;
    logic             accept;
    logic [WIDTH-1:0] grant_word;

    // Grant: external select ignores in_valid so in_ready stays independent of it.
    always_comb begin
        int idx;
        grant_vld = 1'b0;
        grant_idx = '0;
        idx       = 0;
        if (MODE == 0) begin
            if ({1'b0, sel} < (SELW+1)'(N)) begin
                grant_vld = 1'b1;
                grant_idx = sel;
            end
        end else begin
            // Walk from the farthest offset down so the nearest valid channel to ptr wins.
            for (int k = N-1; k >= 0; k--) begin
                idx = int'(ptr_q) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (in_valid[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = SELW'(idx);
                end
            end
        end
    end

    assign space      = !out_valid_q || out_ready;
    assign accept     = grant_vld && in_valid[grant_idx] && space;
    assign grant_word = in_data[grant_idx*WIDTH +: WIDTH];

    for (genvar i = 0; i < N; i++) begin : g_ready
        assign in_ready[i] = space && grant_vld && (grant_idx == SELW'(i));
    end

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_data_d  = grant_word;
            out_src_d   = grant_idx;
            out_valid_d = 1'b1;
            if (MODE == 1) begin
                ptr_d = (grant_idx == SELW'(N-1)) ? '0 : grant_idx + SELW'(1);
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_src_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_src   = out_src_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_stream.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mux_stream                                                              |
// | Directed bench: select mode (N=4, N=6) and round-robin mode (N=4).         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_mux_stream;

    logic clk = 1'b0;
    logic reset_n;

    logic [31:0] d0_data;
    logic [3:0]  d0_valid, d0_ready;
    logic [1:0]  d0_sel, d0_src;
    logic [7:0]  d0_out;
    logic        d0_ov, d0_or;

    logic [31:0] d1_data;
    logic [3:0]  d1_valid, d1_ready;
    logic [1:0]  d1_sel, d1_src;
    logic [7:0]  d1_out;
    logic        d1_ov, d1_or;

    logic [47:0] d2_data;
    logic [5:0]  d2_valid, d2_ready;
    logic [2:0]  d2_sel, d2_src;
    logic [7:0]  d2_out;
    logic        d2_ov, d2_or;

    int checks = 0;
    int errors = 0;

    mux_stream #(.WIDTH(8), .N(4), .MODE(0)) u_sel4 (
        .clk(clk), .reset_n(reset_n), .in_data(d0_data), .in_valid(d0_valid),
        .in_ready(d0_ready), .sel(d0_sel), .out_data(d0_out), .out_valid(d0_ov),
        .out_ready(d0_or), .out_src(d0_src)
    );

    mux_stream #(.WIDTH(8), .N(4), .MODE(1)) u_rr4 (
        .clk(clk), .reset_n(reset_n), .in_data(d1_data), .in_valid(d1_valid),
        .in_ready(d1_ready), .sel(d1_sel), .out_data(d1_out), .out_valid(d1_ov),
        .out_ready(d1_or), .out_src(d1_src)
    );

    mux_stream #(.WIDTH(8), .N(6), .MODE(0)) u_sel6 (
        .clk(clk), .reset_n(reset_n), .in_data(d2_data), .in_valid(d2_valid),
        .in_ready(d2_ready), .sel(d2_sel), .out_data(d2_out), .out_valid(d2_ov),
        .out_ready(d2_or), .out_src(d2_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        d0_data  = '0; d0_valid = '0; d0_sel = '0; d0_or = 1'b0;
        d1_data  = '0; d1_valid = '0; d1_sel = '0; d1_or = 1'b0;
        d2_data  = '0; d2_valid = '0; d2_sel = '0; d2_or = 1'b0;
        #3;
        check("rst_ov",   32'(d0_ov),  32'h0);
        check("rst_data", 32'(d0_out), 32'h0);
        check("rst_src",  32'(d0_src), 32'h0);
        check("rst_rr_ov", 32'(d1_ov), 32'h0);
        step();
        step();
        reset_n = 1'b1;

        // Select mode: sel=2, all valid
        d0_sel   = 2'd2;
        d0_valid = 4'b1111;
        d0_or    = 1'b1;
        d0_data  = {8'h04, 8'hA5, 8'h02, 8'h01};
        #1;
        check("t1_ready", 32'(d0_ready), 32'h4);
        step();
        check("t1_data", 32'(d0_out), 32'hA5);
        check("t1_src",  32'(d0_src), 32'h2);
        check("t1_ov",   32'(d0_ov),  32'h1);

        // Stall holds the word and blocks every input
        d0_or  = 1'b0;
        d0_sel = 2'd0;
        #1;
        check("stall_ready", 32'(d0_ready), 32'h0);
        step();
        check("stall_data", 32'(d0_out), 32'hA5);
        check("stall_src",  32'(d0_src), 32'h2);
        check("stall_ov",   32'(d0_ov),  32'h1);

        // Grant follows sel cycle by cycle
        d0_or  = 1'b1;
        d0_sel = 2'd3;
        #1;
        check("sel3_ready", 32'(d0_ready), 32'h8);
        step();
        check("sel3_data", 32'(d0_out), 32'h04);
        check("sel3_src",  32'(d0_src), 32'h3);
        d0_sel = 2'd0;
        step();
        check("sel0_data", 32'(d0_out), 32'h01);
        check("sel0_src",  32'(d0_src), 32'h0);

        // Back-to-back words from ch0
        d0_valid = 4'b0001;
        for (int k = 0; k < 8; k++) begin
            d0_data[7:0] = 8'(8'h10 + k);
            step();
            check("b2b_data", 32'(d0_out), 32'(8'h10 + k));
            check("b2b_ov",   32'(d0_ov),  32'h1);
        end
        d0_valid = 4'b0000;
        step();
        check("drain_ov",   32'(d0_ov),  32'h0);
        check("drain_data", 32'(d0_out), 32'h17);

        // N=6: out-of-range selects grant nothing
        for (int i = 0; i < 6; i++) begin
            d2_data[i*8 +: 8] = 8'(8'h50 + i);
        end
        d2_valid = 6'h3f;
        d2_or    = 1'b1;
        d2_sel   = 3'd1;
        step();
        check("n6_data", 32'(d2_out), 32'h51);
        check("n6_src",  32'(d2_src), 32'h1);
        d2_sel = 3'd6;
        #1;
        check("n6_sel6_ready", 32'(d2_ready), 32'h0);
        step();
        check("n6_sel6_ov",   32'(d2_ov),  32'h0);
        check("n6_sel6_data", 32'(d2_out), 32'h51);
        check("n6_sel6_src",  32'(d2_src), 32'h1);
        d2_sel = 3'd7;
        #1;
        check("n6_sel7_ready", 32'(d2_ready), 32'h0);
        step();
        check("n6_sel7_ov", 32'(d2_ov), 32'h0);
        d2_sel = 3'd5;
        #1;
        check("n6_sel5_ready", 32'(d2_ready), 32'h20);
        step();
        check("n6_sel5_data", 32'(d2_out), 32'h55);
        check("n6_sel5_src",  32'(d2_src), 32'h5);

        // Round-robin with all channels valid
        d1_data  = {8'h33, 8'h32, 8'h31, 8'h30};
        d1_valid = 4'b1111;
        d1_or    = 1'b1;
        #1;
        check("rr_ready0", 32'(d1_ready), 32'h1);
        for (int k = 0; k < 5; k++) begin
            step();
            check("rr_src",  32'(d1_src), 32'(k % 4));
            check("rr_data", 32'(d1_out), 32'(8'h30 + (k % 4)));
            check("rr_ov",   32'(d1_ov),  32'h1);
        end
        d1_valid = 4'b0000;
        step();
        check("rr_idle_ov", 32'(d1_ov), 32'h0);

        // ch1 and ch3 competing with a 3-cycle stall after the first accept
        d1_valid = 4'b1010;
        #1;
        check("rr4_ready_a", 32'(d1_ready), 32'h2);
        step();
        check("rr4_src_a", 32'(d1_src), 32'h1);
        d1_or = 1'b0;
        #1;
        check("rr4_stall_ready", 32'(d1_ready), 32'h0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("rr4_stall_src",  32'(d1_src), 32'h1);
            check("rr4_stall_data", 32'(d1_out), 32'h31);
            check("rr4_stall_ov",   32'(d1_ov),  32'h1);
        end
        d1_or = 1'b1;
        #1;
        check("rr4_ready_b", 32'(d1_ready), 32'h8);
        step();
        check("rr4_src_b",  32'(d1_src), 32'h3);
        check("rr4_data_b", 32'(d1_out), 32'h33);
        #1;
        check("rr4_ready_c", 32'(d1_ready), 32'h2);

        // Reset mid-transfer with ptr=2
        d1_valid = 4'b1111;
        step();
        check("rr6_src0", 32'(d1_src), 32'h0);
        step();
        check("rr6_src1", 32'(d1_src), 32'h1);
        check("rr6_ov",   32'(d1_ov),  32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_ov",   32'(d1_ov),  32'h0);
        check("arst_data", 32'(d1_out), 32'h0);
        check("arst_src",  32'(d1_src), 32'h0);
        step();
        reset_n = 1'b1;
        #1;
        check("post_rst_ready", 32'(d1_ready), 32'h1);
        step();
        check("post_rst_src",  32'(d1_src), 32'h0);
        check("post_rst_data", 32'(d1_out), 32'h30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
